// File: rtl/seq_shift_acc.sv
// seq_shift_acc: multi-cycle shift accumulator. After a start is accepted, one
// W-bit shift amount is applied to the accumulator per clock. The captured
// mode selects the shift operator. The final value is published on 'a' with a
// one-cycle 'done' pulse.
module seq_shift_acc #(
  parameter  int W  = 10,
  parameter  int N  = 48,
  localparam int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   seed,
  input  logic [N*W-1:0] b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   a
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [W-1:0]  W_VAL = W'(W);

  state_t         state_q, state_d;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic [W-1:0]   chunk;
  logic [CW-1:0]  cnt;
  logic [N*W-1:0] b_q;
  logic [1:0]     mode_q;
  logic           accept;

  // Apply one shift. Amounts of W or more saturate to the fully shifted-out
  // value, so the result never depends on how a tool treats oversized shifts.
  function automatic logic [W-1:0] shift_op(input logic [W-1:0] v,
                                            input logic [W-1:0] s,
                                            input logic [1:0]   m);
    logic [W-1:0] r;
    logic         big;
    big = (s >= W_VAL);
    case (m)
      2'b01:   r = big ? '0 : (v >> s);
      2'b11:   r = big ? {W{v[W-1]}} : W'($signed(v) >>> s);
      default: r = big ? '0 : (v << s);  // logical and arithmetic left match
    endcase
    return r;
  endfunction

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign busy     = (state_q == RUN);
  assign accept   = ready && start && !abort;
  assign chunk    = b_q[int'(cnt) * W +: W];
  assign acc_next = shift_op(acc, chunk, mode_q);

  // Next-state decode: abort always wins, and DONE lasts exactly one cycle.
  always_comb begin
    // NOTE: default assignment first, so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (abort)            state_d = IDLE;
        else if (cnt == LAST) state_d = DONE;
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    else        state_q <= state_d;
  end

  // Datapath: capture operands at acceptance, then one shift per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      a      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        b_q    <= b;
        mode_q <= mode;
        acc    <= seed;
        cnt    <= '0;
      end else if (state_q == RUN && !abort) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          a    <= acc_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_acc.sv
// Bench for seq_shift_acc: directed vectors on the default W=10/N=48 build,
// hand-written multi-cycle corner cases, and random sweeps of two small builds
// against a reference loop.
module tb_seq_shift_acc;

  localparam int W = 10;
  localparam int N = 48;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, abort = 1'b0;
  logic [1:0]   mode = '0;
  logic [W-1:0] seed = '0;
  logic [N*W-1:0] b = '0;
  logic         ready, busy, done;
  logic [W-1:0] a;

  // W=2, N=1 build
  logic         s1_start = 1'b0;
  logic [1:0]   s1_mode = '0, s1_seed = '0, s1_b = '0, s1_a;
  logic         s1_ready, s1_busy, s1_done;

  // W=16, N=3 build
  logic         s3_start = 1'b0;
  logic [1:0]   s3_mode = '0;
  logic [15:0]  s3_seed = '0, s3_a;
  logic [47:0]  s3_b = '0;
  logic         s3_ready, s3_busy, s3_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_shift_acc #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .b(b), .ready(ready), .busy(busy), .done(done), .a(a)
  );

  seq_shift_acc #(.W(2), .N(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(1'b0), .mode(s1_mode),
    .seed(s1_seed), .b(s1_b), .ready(s1_ready), .busy(s1_busy), .done(s1_done), .a(s1_a)
  );

  seq_shift_acc #(.W(16), .N(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .abort(1'b0), .mode(s3_mode),
    .seed(s3_seed), .b(s3_b), .ready(s3_ready), .busy(s3_busy), .done(s3_done), .a(s3_a)
  );

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic [W-1:0] seed;
    int           i0;
    logic [W-1:0] v0;
    int           i1;
    logic [W-1:0] v1;
    logic [W-1:0] exp_a;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference step written from the shift rules with explicit masks, w <= 16.
  function automatic logic [15:0] ref_step(input logic [15:0] v, input int w,
                                           input logic [15:0] s, input logic [1:0] m);
    logic [15:0] mask;
    logic        sgn;
    mask = 16'((32'd1 << w) - 1);
    sgn  = v[w-1];
    if (m[0] == 1'b0)      return (int'(s) >= w) ? 16'd0 : ((v << s) & mask);
    else if (m == 2'b01)   return (int'(s) >= w) ? 16'd0 : (v >> s);
    else if (int'(s) >= w) return sgn ? mask : 16'd0;
    else                   return (v >> s) | (sgn ? (mask & ~(mask >> s)) : 16'd0);
  endfunction

  function automatic logic [15:0] ref_op(input logic [15:0] seed_v, input int w, input int n,
                                         input logic [47:0] bv, input logic [1:0] m);
    logic [15:0] acc_v, mask;
    mask  = 16'((32'd1 << w) - 1);
    acc_v = seed_v;
    for (int k = 0; k < n; k++) acc_v = ref_step(acc_v, w, 16'(bv >> (k * w)) & mask, m);
    return acc_v;
  endfunction

  // Present one request for one edge, then scramble inputs to prove capture.
  task automatic start_op(input logic [1:0] m, input logic [W-1:0] s, input logic [N*W-1:0] bv);
    mode = m; seed = s; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); seed = W'($urandom);
    for (int i = 0; i < 15; i++) b[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    logic [N*W-1:0] bv;
    int cyc, cyc2, dcnt;
    logic [15:0] exp16;

    vecs[0]  = '{"all_zero",     2'b00, 10'h001,  0, 10'd0,  47, 10'd0, 10'h001};
    vecs[1]  = '{"lsl_c0_3",     2'b00, 10'h001,  0, 10'd3,  47, 10'd0, 10'h008};
    vecs[2]  = '{"lsl_c5_12",    2'b00, 10'h001,  5, 10'd12, 47, 10'd0, 10'h000};
    vecs[3]  = '{"asr_c0_2",     2'b11, 10'h200,  0, 10'd2,  47, 10'd0, 10'h380};
    vecs[4]  = '{"lsr_c0_2",     2'b01, 10'h200,  0, 10'd2,  47, 10'd0, 10'h080};
    vecs[5]  = '{"asr_c0_15",    2'b11, 10'h200,  0, 10'd15, 47, 10'd0, 10'h3FF};
    vecs[6]  = '{"lsr_two",      2'b01, 10'h3FF, 10, 10'd4,  20, 10'd5, 10'h001};
    vecs[7]  = '{"asr_pos",      2'b11, 10'h155,  0, 10'd1,   1, 10'd1, 10'h055};
    vecs[8]  = '{"asr_s_eq_w",   2'b11, 10'h2AA,  0, 10'd10, 47, 10'd0, 10'h3FF};
    vecs[9]  = '{"lsr_s_eq_w",   2'b01, 10'h200,  0, 10'd10, 47, 10'd0, 10'h000};
    vecs[10] = '{"lsl_s_max",    2'b00, 10'h3FF,  3, 10'h3FF, 47, 10'd0, 10'h000};
    vecs[11] = '{"lsl_s_wm1",    2'b00, 10'h001,  0, 10'd9,  47, 10'd0, 10'h200};
    vecs[12] = '{"asl_c0_c47",   2'b10, 10'h001,  0, 10'd3,  47, 10'd2, 10'h020};

    // Reset defaults.
    #1 rst_n = 1'b0;
    #1;
    check("reset_a", a, 0);
    check("reset_done", done, 0);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: latency, result, single-cycle done.
    for (int i = 0; i < 13; i++) begin
      bv = '0;
      bv[vecs[i].i1*W +: W] = vecs[i].v1;
      bv[vecs[i].i0*W +: W] = vecs[i].v0;
      start_op(vecs[i].mode, vecs[i].seed, bv);
      check({vecs[i].name, "_busy"}, {ready, busy}, 2'b01);
      wait_done(100, cyc);
      check({vecs[i].name, "_latency"}, cyc, N);
      check({vecs[i].name, "_a"}, a, vecs[i].exp_a);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_1cyc"}, {done, ready}, 2'b01);
    end

    // Asynchronous reset in the middle of RUN: outputs clear before any edge.
    start_op(2'b00, 10'h001, '0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_a", a, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_ready", ready, 1);
    check("midrun_reset_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bv = '0; bv[0 +: W] = 10'd1;
    start_op(2'b00, 10'h001, bv);
    wait_done(100, cyc);
    check("after_reset_latency", cyc, N);
    check("after_reset_a", a, 10'h002);
    @(posedge clk); #1;

    // Back-to-back with start held: the first op keeps its captured b.
    bv = '0; bv[0 +: W] = 10'd1;
    mode = 2'b00; seed = 10'h001; b = bv; start = 1'b1;
    @(posedge clk); #1;
    bv = '0; bv[0 +: W] = 10'd3;
    mode = 2'b01; seed = 10'h3FF; b = bv;
    wait_done(100, cyc);
    check("b2b_first_latency", cyc, N);
    check("b2b_first_a", a, 10'h002);
    @(posedge clk); #1;
    check("b2b_reaccepted", {busy, done}, 2'b10);
    start = 1'b0; seed = 10'h000; b = '0; mode = 2'b00;
    wait_done(100, cyc2);
    // Period is N RUN cycles plus the DONE cycle in which the restart is accepted.
    check("b2b_done_gap", cyc2 + 1, N + 1);
    check("b2b_second_a", a, 10'h07F);
    @(posedge clk); #1;

    // Abort at RUN cycle 20: no done, a unchanged, ready next cycle.
    start_op(2'b00, 10'h001, '0);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", {ready, busy}, 2'b10);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_a_kept", a, 10'h07F);

    // start together with abort in IDLE is not accepted.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {ready, busy}, 2'b10);

    // start during RUN is ignored; the original operation completes.
    bv = '0; bv[2*W +: W] = 10'd4;
    start_op(2'b00, 10'h001, bv);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; seed = 10'h3FF; b = '0; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, cyc);
    check("start_in_run_latency", cyc, N - 6);
    check("start_in_run_a", a, 10'h010);
    @(posedge clk); #1;

    // Random sweep, W=2 N=1 (amounts 2 and 3 are >= W).
    for (int i = 0; i < 5000; i++) begin
      s1_mode = 2'($urandom); s1_seed = 2'($urandom); s1_b = 2'($urandom);
      exp16 = ref_op(16'(s1_seed), 2, 1, 48'(s1_b), s1_mode);
      s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0; s1_b = 2'($urandom); s1_seed = 2'($urandom);
      cyc = 0;
      while (!s1_done && cyc < 10) begin @(posedge clk); #1; cyc++; end
      check("sweep_n1_latency", cyc, 1);
      check("sweep_n1_a", s1_a, exp16[1:0]);
    end

    // Random sweep, W=16 N=3, amounts biased around the W boundary.
    for (int i = 0; i < 5000; i++) begin
      s3_mode = 2'($urandom); s3_seed = 16'($urandom);
      for (int k = 0; k < 3; k++)
        s3_b[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      exp16 = ref_op(s3_seed, 16, 3, s3_b, s3_mode);
      s3_start = 1'b1;
      @(posedge clk); #1;
      s3_start = 1'b0; s3_b = {16'($urandom), 32'($urandom)}; s3_seed = 16'($urandom);
      cyc = 0;
      while (!s3_done && cyc < 10) begin @(posedge clk); #1; cyc++; end
      check("sweep_n3_latency", cyc, 3);
      check("sweep_n3_a", s3_a, exp16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
